// File: rtl/neuron_pkg.sv
// Shared types and default sizes for the neuron MAC sequencer.
package neuron_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 20;
  localparam int Y_MAX      = (1 << (DEF_DATA_W - 1)) - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    ACT  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/neuron_mac_sequencer_operand_reg.sv
// Load-enabled operand register with synchronous active-high clear.
module operand_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Capture the operand when loaded, otherwise hold it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// One neuron: streams in (x, w) pairs, multiply-accumulates them, adds a bias,
// applies ReLU with saturation and offers the result on a valid/ready output.
module neuron_mac_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = neuron_pkg::DEF_DATA_W,
  parameter int ACC_W    = neuron_pkg::DEF_ACC_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_out,
  output logic              busy
);

  import neuron_pkg::*;

  // Counter only needs to reach N_INPUTS-1; it is cleared on every start.
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0]         CNT_LAST    = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0]  Y_LIMIT_ACC = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic [DATA_W-1:0]        Y_LIMIT     = DATA_W'((1 << (DATA_W - 1)) - 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        bias_q, bias_d;
  logic [DATA_W-1:0]        y_q, y_d;

  logic                     load_ops;
  logic [DATA_W-1:0]        x_q, w_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum_act;
  logic [DATA_W-1:0]        y_act;

  operand_reg #(.W(DATA_W)) u_x_reg (
    .clk_i  (CLK),
    .rst_i  (reset),
    .load_i (load_ops),
    .d_i    (x_in),
    .q_o    (x_q)
  );

  operand_reg #(.W(DATA_W)) u_w_reg (
    .clk_i  (CLK),
    .rst_i  (reset),
    .load_i (load_ops),
    .d_i    (w_in),
    .q_o    (w_q)
  );

  // Full-precision signed product and biased sum feeding the activation.
  always_comb begin
    prod    = signed'(x_q) * signed'(w_q);
    sum_act = acc_q + ACC_W'(signed'(bias_q));
  end

  // ReLU with saturation to the positive range of DATA_W.
  always_comb begin
    y_act = '0;
    if (sum_act[ACC_W-1]) begin
      y_act = '0;
    end else if (sum_act > Y_LIMIT_ACC) begin
      y_act = Y_LIMIT;
    end else begin
      y_act = sum_act[DATA_W-1:0];
    end
  end

  // Next-state and datapath update for the evaluation sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bias_d   = bias_q;
    y_d      = y_q;
    load_ops = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          bias_d  = bias;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          load_ops = 1'b1;
          state_d  = MAC;
        end else begin
          state_d  = LOAD;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ACT;
        end else begin
          state_d = LOAD;
        end
      end
      ACT: begin
        y_d     = y_act;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial evaluation.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y_out     = y_q;

endmodule
